// File: rtl/rr_mux_arb_if.sv
// ---------------------------------------------------------------------------
// rr_mux_arb_if
// Handshake/bus bundle for rr_mux_arb.
//   din        packed channel data, channel k at [k*DATA_W +: DATA_W]
//   din_valid  per-channel valid
//   din_ready  per-channel ready (one-hot or zero)
//   mode       0 = round-robin, 1 = fixed select
//   sel        channel index used in fixed mode
//   dout       registered output word
//   dout_sel   index of the channel that produced dout
//   dout_valid output stage holds a word
//   dout_ready consumer accepts dout this cycle
// Modports: slave = arbiter side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface rr_mux_arb_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_CH*DATA_W-1:0] din;
  logic [NUM_CH-1:0]        din_valid;
  logic [NUM_CH-1:0]        din_ready;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [DATA_W-1:0]        dout;
  logic [SEL_W-1:0]         dout_sel;
  logic                     dout_valid;
  logic                     dout_ready;

  modport slave (
    input  din, din_valid, mode, sel, dout_ready,
    output din_ready, dout, dout_sel, dout_valid
  );

  modport master (
    output din, din_valid, mode, sel, dout_ready,
    input  din_ready, dout, dout_sel, dout_valid
  );
endinterface

// File: rtl/rr_mux_arb.sv
// ---------------------------------------------------------------------------
// rr_mux_arb
// Registered NUM_CH:1 data multiplexer with valid/ready handshakes. Each
// cycle in which the output stage is empty or being consumed, one channel is
// granted (round-robin from a rotating pointer, or a fixed index) and its
// word is captured into the single output register.
// Ports:
//   clk       system clock, all state on the rising edge
//   rst       synchronous reset, active-high
//   bus       rr_mux_arb_if.slave handshake bundle (see interface file)
//   xfer_cnt  16-bit output handshake counter, present only when the macro
//             RR_MUX_XFER_CNT_EN is defined
// ---------------------------------------------------------------------------
module rr_mux_arb #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  rr_mux_arb_if.slave       bus
`ifdef RR_MUX_XFER_CNT_EN
  ,
  output logic [15:0]       xfer_cnt
`endif
);

  logic [DATA_W-1:0] data_p1_q, data_p1_d;
  logic [SEL_W-1:0]  sel_p1_q,  sel_p1_d;
  logic              vld_p1_q,  vld_p1_d;
  logic [SEL_W-1:0]  ptr_q,     ptr_d;

  logic              load_en;
  logic              rr_found, fx_found, gnt_found, grant_en;
  logic [SEL_W-1:0]  rr_idx, gnt_idx;
  logic [DATA_W-1:0] gnt_data;
  logic [NUM_CH-1:0] din_ready_w;

  assign load_en = !vld_p1_q || bus.dout_ready;

  // Round-robin: each valid channel's distance from ptr, smallest wins.
  always_comb begin
    int best_d;
    int d;
    rr_found = 1'b0;
    rr_idx   = '0;
    best_d   = NUM_CH;
    d        = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      d = (k - int'(ptr_q) + NUM_CH) % NUM_CH;
      if (bus.din_valid[k] && d < best_d) begin
        best_d   = d;
        rr_found = 1'b1;
        rr_idx   = SEL_W'(k);
      end
    end
  end

  // Fixed select: out-of-range sel never matches any channel.
  always_comb begin
    fx_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.din_valid[k] && int'(bus.sel) == k) fx_found = 1'b1;
    end
  end

  assign gnt_found = bus.mode ? fx_found : rr_found;
  assign gnt_idx   = bus.mode ? bus.sel  : rr_idx;
  assign grant_en  = load_en && gnt_found && !rst;

  always_comb begin
    gnt_data    = '0;
    din_ready_w = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(gnt_idx) == k) begin
        gnt_data       = bus.din[k*DATA_W +: DATA_W];
        din_ready_w[k] = grant_en;
      end
    end
  end

  always_comb begin
    int nxt;
    data_p1_d = data_p1_q;
    sel_p1_d  = sel_p1_q;
    vld_p1_d  = vld_p1_q;
    ptr_d     = ptr_q;
    nxt       = int'(gnt_idx) + 1;
    if (nxt >= NUM_CH) nxt = 0;
    if (load_en) begin
      // Empty or consumed: an idle arbitration drops valid but keeps the word.
      vld_p1_d = gnt_found;
      if (gnt_found) begin
        data_p1_d = gnt_data;
        sel_p1_d  = gnt_idx;
        if (!bus.mode) ptr_d = SEL_W'(nxt);
      end
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1_q <= '0;
      sel_p1_q  <= '0;
      vld_p1_q  <= 1'b0;
      ptr_q     <= '0;
    end else begin
      data_p1_q <= data_p1_d;
      sel_p1_q  <= sel_p1_d;
      vld_p1_q  <= vld_p1_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.din_ready  = din_ready_w;
  assign bus.dout       = data_p1_q;
  assign bus.dout_sel   = sel_p1_q;
  assign bus.dout_valid = vld_p1_q;

`ifdef RR_MUX_XFER_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = cnt_q + {15'd0, (vld_p1_q && bus.dout_ready)};

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule
